pc_fetch_unit: RTL

//   Holds the architectural PC and fetches one instruction at a time over a valid/ready

---
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Architectural PC holder and single-outstanding instruction fetcher (IDLE/REQ/WAIT/EXEC FSM).
// Optional PC_MISALIGN_CHECK_EN halts on a misaligned committed target and raises misalign_err.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            commit,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1 + imm;

    always_comb begin
        next_pc = pc_q + XLEN'(4);
        case (pc_src)
            2'b00: next_pc = pc_q + XLEN'(4);
            2'b01: next_pc = pc_q + imm;
            2'b10: next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            2'b11: next_pc = csr_pc;
            default: next_pc = pc_q + XLEN'(4);
        endcase
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
`ifdef PC_MISALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // Response in the same cycle as the handshake is deliberately not sampled.
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d       = imem_resp_data;
                    inst_valid_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    pc_d         = next_pc;
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
`ifdef PC_MISALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end
`endif
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            req_valid_q  <= req_valid_d;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
`ifdef PC_MISALIGN_CHECK_EN
    assign misalign_err   = misalign_q;
`else
    assign misalign_err   = 1'b0;
`endif

endmodule
